// File: rtl/id_pair_packer_pkg.sv
// Shared widths, beat payload and lane->tkeep helper for the ID pair packer
// and the host-side result unpacker.
package id_pair_packer_pkg;

  localparam int unsigned BUS_WIDTH      = 128;
  localparam int unsigned VEC_ID_WIDTH   = 8;
  localparam int unsigned PAIR_WIDTH     = 2 * VEC_ID_WIDTH;
  localparam int unsigned PAIRS_PER_BEAT = BUS_WIDTH / PAIR_WIDTH;
  localparam int unsigned LANE_CNT_WIDTH = $clog2(PAIRS_PER_BEAT) + 1;
  localparam int unsigned PAIR_CNT_WIDTH = 32;
  localparam int unsigned KEEP_WIDTH     = BUS_WIDTH / 8;
  localparam int unsigned LANE_BYTES     = PAIR_WIDTH / 8;

  typedef logic [PAIR_WIDTH-1:0]     pair_t;
  typedef logic [BUS_WIDTH-1:0]      bus_t;
  typedef logic [KEEP_WIDTH-1:0]     keep_t;
  typedef logic [LANE_CNT_WIDTH-1:0] lane_cnt_t;
  typedef logic [PAIR_CNT_WIDTH-1:0] pair_cnt_t;

  // One packed output beat: lane 0 in the data LSBs.
  typedef struct packed {
    logic  last;
    keep_t keep;
    bus_t  data;
  } beat_t;

  // Byte enables for the first n_lanes lanes (lanes always fill from lane 0).
  function automatic keep_t lane_keep_mask(input lane_cnt_t n_lanes);
    keep_t mask;
    mask = '0;
    for (int unsigned k = 0; k < PAIRS_PER_BEAT; k++) begin
      if (32'(n_lanes) > k) mask[k*LANE_BYTES +: LANE_BYTES] = '1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/id_pair_packer_if.sv
// AXI4-Stream bundles: the narrow ID pair input stream and the packed output stream.
interface id_pair_stream_if;
  import id_pair_packer_pkg::*;

  pair_t tdata;
  logic  tvalid;
  logic  tlast;
  logic  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

interface packed_stream_if;
  import id_pair_packer_pkg::*;

  bus_t  tdata;
  keep_t tkeep;
  logic  tvalid;
  logic  tlast;
  logic  tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/id_pair_out_reg.sv
// Output beat register: holds a packed beat stable until the downstream accepts it.
module id_pair_out_reg
  import id_pair_packer_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  beat_t load_beat,
  input  logic  ready,
  output logic  valid,
  output beat_t beat,
  output logic  done,
  output logic  drain_c
);

  assign drain_c = valid && ready;

  // Load has priority: a same-edge drain and refill keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      beat  <= '0;
      done  <= 1'b0;
    end else begin
      done <= drain_c && beat.last;
      if (load) begin
        valid <= 1'b1;
        beat  <= load_beat;
      end else if (drain_c) begin
        valid <= 1'b0;
        beat  <= '0;
      end
    end
  end

endmodule

// File: rtl/id_pair_packer.sv
// Packs PAIRS_PER_BEAT ID pairs into one wide AXI4-Stream beat; partial beats
// flush on tlast. Counts pairs per stream and pulses o_Done after the last beat.
module id_pair_packer
  import id_pair_packer_pkg::*;
(
  input  logic                ap_clk,
  input  logic                ap_rstn,
  id_pair_stream_if.slave     s_axis_id_pair,
  packed_stream_if.master     m_axis_packed,
  output logic [PAIR_CNT_WIDTH-1:0] o_PairCount,
  output logic                o_Done
);

  bus_t      acc_data_q, acc_data_d;
  lane_cnt_t lane_cnt_q, lane_cnt_d;
  logic      acc_pending_q, acc_pending_d;
  logic      pend_last_q, pend_last_d;
  logic      ready_q, ready_d;
  pair_cnt_t cnt_q, cnt_d;
  logic      closed_q, closed_d;

  bus_t      lane_data_c;
  lane_cnt_t lane_cnt_inc_c;
  logic      in_hs_c;
  logic      out_free_c;
  logic      beat_full_c;
  logic      load_c;
  beat_t     load_beat_c;

  logic      out_valid;
  beat_t     out_beat;
  logic      out_done;
  logic      out_drain_c;

  id_pair_out_reg u_out_reg (
    .clk       (ap_clk),
    .rst_n     (ap_rstn),
    .load      (load_c),
    .load_beat (load_beat_c),
    .ready     (m_axis_packed.tready),
    .valid     (out_valid),
    .beat      (out_beat),
    .done      (out_done),
    .drain_c   (out_drain_c)
  );

  assign m_axis_packed.tvalid = out_valid;
  assign m_axis_packed.tdata  = out_beat.data;
  assign m_axis_packed.tkeep  = out_beat.keep;
  assign m_axis_packed.tlast  = out_beat.last;
  assign s_axis_id_pair.tready = ready_q;
  assign o_PairCount = cnt_q;
  assign o_Done      = out_done;

  // Lane packing, ACC->OUT hand-off, back-pressure and per-stream pair count.
  always_comb begin
    acc_data_d    = acc_data_q;
    lane_cnt_d    = lane_cnt_q;
    acc_pending_d = acc_pending_q;
    pend_last_d   = pend_last_q;
    cnt_d         = cnt_q;
    closed_d      = closed_q;
    load_c        = 1'b0;
    load_beat_c   = '0;

    lane_data_c = acc_data_q;
    for (int unsigned k = 0; k < PAIRS_PER_BEAT; k++) begin
      if (lane_cnt_q == LANE_CNT_WIDTH'(k)) lane_data_c[k*PAIR_WIDTH +: PAIR_WIDTH] = s_axis_id_pair.tdata;
    end
    lane_cnt_inc_c = lane_cnt_q + LANE_CNT_WIDTH'(1);
    in_hs_c        = s_axis_id_pair.tvalid && ready_q;
    out_free_c     = !out_valid || m_axis_packed.tready;
    beat_full_c    = (lane_cnt_inc_c == LANE_CNT_WIDTH'(PAIRS_PER_BEAT));

    if (in_hs_c) begin
      closed_d = s_axis_id_pair.tlast;
      if (closed_q)        cnt_d = PAIR_CNT_WIDTH'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + PAIR_CNT_WIDTH'(1);
    end

    if (acc_pending_q) begin
      // A completed beat is parked in ACC; move it as soon as OUT drains.
      if (out_drain_c) begin
        load_c           = 1'b1;
        load_beat_c.data = acc_data_q;
        load_beat_c.keep = lane_keep_mask(lane_cnt_q);
        load_beat_c.last = pend_last_q;
        acc_data_d       = '0;
        lane_cnt_d       = '0;
        acc_pending_d    = 1'b0;
        pend_last_d      = 1'b0;
      end
    end else if (in_hs_c) begin
      if (beat_full_c || s_axis_id_pair.tlast) begin
        if (out_free_c) begin
          load_c           = 1'b1;
          load_beat_c.data = lane_data_c;
          load_beat_c.keep = lane_keep_mask(lane_cnt_inc_c);
          load_beat_c.last = s_axis_id_pair.tlast;
          acc_data_d       = '0;
          lane_cnt_d       = '0;
        end else begin
          acc_data_d    = lane_data_c;
          lane_cnt_d    = lane_cnt_inc_c;
          acc_pending_d = 1'b1;
          pend_last_d   = s_axis_id_pair.tlast;
        end
      end else begin
        acc_data_d = lane_data_c;
        lane_cnt_d = lane_cnt_inc_c;
      end
    end

    ready_d = !acc_pending_d;
  end

  // Packer state registers; tready stays low during reset and rises on the first edge after.
  always_ff @(posedge ap_clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      acc_data_q    <= '0;
      lane_cnt_q    <= '0;
      acc_pending_q <= 1'b0;
      pend_last_q   <= 1'b0;
      ready_q       <= 1'b0;
      cnt_q         <= '0;
      closed_q      <= 1'b0;
    end else begin
      acc_data_q    <= acc_data_d;
      lane_cnt_q    <= lane_cnt_d;
      acc_pending_q <= acc_pending_d;
      pend_last_q   <= pend_last_d;
      ready_q       <= ready_d;
      cnt_q         <= cnt_d;
      closed_q      <= closed_d;
    end
  end

endmodule
